// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one combinational ALU between two requesters.
// One transaction at a time: accept (IDLE) -> compute (EXEC) -> respond (RESP).
module alu_share_ctrl #(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  output logic              req0_ready,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_carry,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              req1_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_carry,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_select,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [SEL_W-1:0] SEL_ADD = SEL_W'(3);

  logic [1:0]        state;
  logic              ptr;
  logic              owner;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [SEL_W-1:0]  op_sel;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;

  logic grant_any;
  logic grant_id;
  logic rsp_fire;

  // Requester at ptr has priority; the other one is served only when ptr is idle.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE) begin
      if (ptr ? req1_valid : req0_valid) begin
        grant_any = 1'b1;
        grant_id  = ptr;
      end else if (ptr ? req0_valid : req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ~ptr;
      end
    end
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any &&  grant_id;

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) &&  owner;
  assign rsp_fire   = owner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

  assign rsp0_data  = res_data;
  assign rsp0_carry = res_carry;
  assign rsp1_data  = res_data;
  assign rsp1_carry = res_carry;

  assign alu_a      = op_a;
  assign alu_b      = op_b;
  assign alu_select = op_sel;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      res_data  <= '0;
      res_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_a   <= grant_id ? req1_a   : req0_a;
            op_b   <= grant_id ? req1_b   : req0_b;
            op_sel <= grant_id ? req1_sel : req0_sel;
            owner  <= grant_id;
            state  <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= alu_out;
          res_carry <= (op_sel == SEL_ADD) ? alu_carry : 1'b0;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_fire) begin
            ptr   <= ~owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios plus random traffic
// checked against a transaction-level model of the shared-ALU protocol.
module tb_alu_share_ctrl;
  localparam int DATA_W = 4;
  localparam int SEL_W  = 2;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  logic              req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_carry;
  logic [DATA_W-1:0] req0_a, req0_b, rsp0_data;
  logic [SEL_W-1:0]  req0_sel;
  logic              req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_carry;
  logic [DATA_W-1:0] req1_a, req1_b, rsp1_data;
  logic [SEL_W-1:0]  req1_sel;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out;
  logic [SEL_W-1:0]  alu_select;
  logic              alu_carry, busy;

  alu_share_ctrl #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset_L(reset_L),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_carry(rsp0_carry),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_carry(rsp1_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_out(alu_out), .alu_carry(alu_carry), .busy(busy)
  );

  // ALU stand-in: its carry always comes from the adder, so the controller must mask it.
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = alu_sum[4];
    case (alu_select)
      2'd0:    alu_out = alu_a & alu_b;
      2'd1:    alu_out = alu_a | alu_b;
      2'd2:    alu_out = alu_a ^ alu_b;
      default: alu_out = alu_sum[3:0];
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_op(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] s);
    case (s)
      2'd0:    return {1'b0, a & b};
      2'd1:    return {1'b0, a | b};
      2'd2:    return {1'b0, a ^ b};
      default: return {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  // Transaction-level model: one outstanding op, age counts cycles since accept.
  bit         m_busy;
  int         m_owner, m_age, m_ptr;
  logic [3:0] m_a, m_b;
  logic [1:0] m_sel;
  int         acc_id;
  int         cyc = 0;

  task automatic cycle(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                       input logic [1:0] s0, input logic v1, input logic [3:0] a1,
                       input logic [3:0] b1, input logic [1:0] s1,
                       input logic r0, input logic r1);
    int g;
    logic [4:0] e;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
    rsp0_ready = r0; rsp1_ready = r1;
    #1;
    g = -1;
    acc_id = -1;
    if (!m_busy) begin
      if (m_ptr == 0) g = v0 ? 0 : (v1 ? 1 : -1);
      else            g = v1 ? 1 : (v0 ? 0 : -1);
    end
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    check("busy", busy, m_busy);
    check("rsp0_valid", rsp0_valid, m_busy && m_age >= 1 && m_owner == 0);
    check("rsp1_valid", rsp1_valid, m_busy && m_age >= 1 && m_owner == 1);
    if (m_busy) begin
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_select", alu_select, m_sel);
      if (m_age >= 1) begin
        e = ref_op(m_a, m_b, m_sel);
        if (m_owner == 0) begin
          check("rsp0_data", rsp0_data, e[3:0]);
          check("rsp0_carry", rsp0_carry, e[4]);
        end else begin
          check("rsp1_data", rsp1_data, e[3:0]);
          check("rsp1_carry", rsp1_carry, e[4]);
        end
      end
    end
    if (g >= 0) begin
      m_busy = 1; m_owner = g; m_age = 0; acc_id = g;
      m_a = g ? a1 : a0; m_b = g ? b1 : b0; m_sel = g ? s1 : s0;
    end else if (m_busy) begin
      if (m_age >= 1 && (m_owner == 0 ? r0 : r1)) begin
        m_busy = 0;
        m_ptr  = 1 - m_owner;
      end else begin
        m_age++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycle(input logic r);
    cycle(0, 4'h0, 4'h0, 2'd0, 0, 4'h0, 4'h0, 2'd0, r, r);
  endtask

  // Issue one op on requester n alone and check the response against literals.
  task automatic single(input int n, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] s, input logic [3:0] ed, input logic ec);
    int k = 0;
    acc_id = -1;
    while (acc_id != n && k < 10) begin
      if (n == 0) cycle(1, a, b, s, 0, 4'h0, 4'h0, 2'd0, 1, 1);
      else        cycle(0, 4'h0, 4'h0, 2'd0, 1, a, b, s, 1, 1);
      k++;
    end
    check("accept", acc_id, n);
    idle_cycle(0);
    check("lit_valid", n ? rsp1_valid : rsp0_valid, 1'b1);
    check("lit_other_valid", n ? rsp0_valid : rsp1_valid, 1'b0);
    check("lit_data", n ? rsp1_data : rsp0_data, ed);
    check("lit_carry", n ? rsp1_carry : rsp0_carry, ec);
    idle_cycle(1);
  endtask

  initial begin
    int ids[$];
    int cycs[$];
    int k;
    logic [3:0] held;

    req0_valid = 0; req0_a = '0; req0_b = '0; req0_sel = '0; rsp0_ready = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_sel = '0; rsp1_ready = 0;
    m_busy = 0; m_owner = 0; m_age = 0; m_ptr = 0; m_a = '0; m_b = '0; m_sel = '0;
    acc_id = -1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_rsp0_valid", rsp0_valid, 1'b0);
    check("rst_rsp1_valid", rsp1_valid, 1'b0);
    check("rst_alu", {alu_a, alu_b, alu_select}, '0);
    check("rst_rsp_data", {rsp0_data, rsp0_carry, rsp1_data, rsp1_carry}, '0);
    reset_L = 1'b1;
    idle_cycle(1);

    single(0, 4'h9, 4'h8, 2'd3, 4'h1, 1'b1);
    single(1, 4'hC, 4'hA, 2'd0, 4'h8, 1'b0);
    single(1, 4'hC, 4'hA, 2'd1, 4'hE, 1'b0);
    single(1, 4'hC, 4'hA, 2'd2, 4'h6, 1'b0);
    single(0, 4'h7, 4'h7, 2'd2, 4'h0, 1'b0);

    // ptr now points at requester 1; reset mid-EXEC must clear it back to 0.
    cycle(0, 4'h0, 4'h0, 2'd0, 1, 4'hF, 4'h3, 2'd3, 1, 1);
    check("pre_rst_accept", acc_id, 1);
    req1_valid = 0;
    reset_L = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    check("mid_rst_alu", {alu_a, alu_b, alu_select}, '0);
    check("mid_rst_rsp_data", {rsp0_data, rsp0_carry, rsp1_data, rsp1_carry}, '0);
    m_busy = 0; m_ptr = 0;
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    repeat (3) idle_cycle(1);

    // Contention: both valid continuously.
    for (int i = 0; i < 13; i++) begin
      cycle(1, 4'($urandom), 4'($urandom), 2'($urandom), 1, 4'($urandom), 4'($urandom),
            2'($urandom), 1, 1);
      if (acc_id >= 0) begin
        ids.push_back(acc_id);
        cycs.push_back(cyc);
      end
    end
    check("cont_accepts", ids.size(), 5);
    for (int i = 0; i < ids.size(); i++) begin
      check("cont_grant", ids[i], i % 2);
      if (i > 0) check("cont_spacing", cycs[i] - cycs[i-1], 3);
    end

    // Backpressure on requester 0 with requester 1 waiting.
    k = 0;
    while (busy && k < 6) begin idle_cycle(1); k++; end
    check("bp_idle", busy, 1'b0);
    acc_id = -1;
    k = 0;
    while (acc_id != 0 && k < 6) begin
      cycle(1, 4'h6, 4'h5, 2'd3, 0, 4'h0, 4'h0, 2'd0, 0, 0);
      k++;
    end
    check("bp_accept", acc_id, 0);
    cycle(0, 4'h1, 4'h1, 2'd0, 1, 4'h2, 4'h3, 2'd1, 0, 0);
    held = rsp0_data;
    check("bp_data", held, 4'hB);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 4'($urandom), 4'h0, 2'd0, 1, 4'h2, 4'h3, 2'd1, 0, 1);
      check("bp_req1_ready", req1_ready, 1'b0);
      check("bp_stable", rsp0_data, held);
    end
    cycle(0, 4'h0, 4'h0, 2'd0, 1, 4'h2, 4'h3, 2'd1, 1, 1);
    cycle(0, 4'h0, 4'h0, 2'd0, 1, 4'h2, 4'h3, 2'd1, 1, 1);
    check("bp_next_grant", acc_id, 1);

    // Random traffic; operands change every cycle so capture-only-at-accept is exercised.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 2'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
